// File: rtl/c17_bist_array.sv
// LANES copies of the c17 benchmark core sharing one pattern LFSR, with MISR
// compaction and golden-signature compare. Cores are usable combinationally in IDLE/DONE.
module c17_bist_array #(
    parameter int                LANES     = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_TAPS = 16'hB400,
    parameter int                PATTERNS  = 255,
    localparam int               CNT_W     = $clog2(PATTERNS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LFSR_W-1:0]    seed,
    input  logic [MISR_W-1:0]    golden,
    input  logic [2*LANES-1:0]   fault_mask,
    input  logic [5*LANES-1:0]   func_in,
    output logic [2*LANES-1:0]   func_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [MISR_W-1:0]    signature,
    output logic [CNT_W-1:0]     pattern_count
);

    localparam logic [CNT_W-1:0] PAT_MAX = CNT_W'(PATTERNS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic                 load, step;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [MISR_W-1:0]    sig_q;
    logic [CNT_W-1:0]     count_q, count_next;
    logic [5*LANES-1:0]   bist_in;
    logic [2*LANES-1:0]   func_core, bist_core;

    // Input order per lane is {in7, in6, in3, in2, in1}; result is {o23, o22}.
    function automatic logic [1:0] c17_core(input logic [4:0] x);
        logic n10, n11, n16, n19;
        n10 = ~(x[0] & x[2]);
        n11 = ~(x[2] & x[3]);
        n16 = ~(x[1] & n11);
        n19 = ~(n11 & x[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [MISR_W-1:0] fold(input logic [2*LANES-1:0] d);
        logic [MISR_W-1:0] f;
        f = '0;
        for (int m = 0; m < 2*LANES; m++) f[m % MISR_W] ^= d[m];
        return f;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == PAT_MAX) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        bist_in = '0;
        for (int k = 0; k < LANES; k++)
            for (int j = 0; j < 5; j++)
                bist_in[5*k+j] = lfsr_q[(5*k+j) % LFSR_W];
    end

    always_comb begin
        func_core = '0;
        bist_core = '0;
        for (int k = 0; k < LANES; k++) begin
            func_core[2*k +: 2] = c17_core(func_in[5*k +: 5]);
            bist_core[2*k +: 2] = c17_core(bist_in[5*k +: 5]);
        end
    end

    assign count_next = sat_inc(count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // abort outranks start; start is only honoured from IDLE or DONE.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pass     = 1'b0;
        func_out = func_core;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    done = 1'b1;
                    pass = (sig_q == golden);
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                func_out = '0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (count_next == PAT_MAX) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A zero seed would lock the LFSR, so it is promoted to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_W'(1);
            sig_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            lfsr_q  <= (seed == '0) ? LFSR_W'(1) : seed;
            sig_q   <= '0;
            count_q <= '0;
        end else if (step) begin
            lfsr_q  <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            sig_q   <= {sig_q[MISR_W-2:0], ^(sig_q & MISR_TAPS)} ^ fold(bist_core ^ fault_mask);
            count_q <= count_next;
        end
    end

    assign signature     = sig_q;
    assign pattern_count = count_q;

endmodule

// File: doc/c17_bist_array.md
Name: c17_bist_array

Overview:
- Parametrised multi-lane successor of the c17 benchmark core with built-in self-test.
- LANES identical c17 cores share one pattern LFSR. Their outputs compact into a MISR signature, which is compared against a golden value.
- In IDLE the cores are usable functionally, as a pure combinational path. The block is a fault-simulation and self-test target for the benchmark suite.

Parameters:
- LANES, 4: number of c17 cores (1..16).
- LFSR_W, 16: pattern LFSR width (must be >= 5).
- LFSR_TAPS, 16'hB400: Fibonacci feedback mask; feedback = XOR of (lfsr & LFSR_TAPS), shifted in at bit 0.
- MISR_W, 16: signature width.
- MISR_TAPS, 16'hB400: MISR feedback mask.
- PATTERNS, 255: patterns per run (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a BIST run; sampled in IDLE or DONE.
- abort  in  1  return to IDLE from any state; has priority over start.
- seed  in  LFSR_W  LFSR seed, captured on start.
- golden  in  MISR_W  expected signature, compared in DONE.
- fault_mask  in  2*LANES  XORed onto core outputs during RUN only.
- func_in  in  5*LANES  lane k bits [5k+4:5k] = {in7, in6, in3, in2, in1}.
- func_out  out  2*LANES  lane k bits [2k+1:2k] = {o23, o22}.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done; signature == golden.
- signature  out  MISR_W  current MISR value.
- pattern_count  out  clog2(PATTERNS+1)  patterns applied in the current or last run.

Behaviour:
- Core function, per lane:
  - n10 = NAND(in1, in3); n11 = NAND(in3, in6)
  - n16 = NAND(in2, n11); n19 = NAND(n11, in7)
  - o22 = NAND(n10, n16); o23 = NAND(n16, n19)
- Reset (async, rst_n = 0):
  - State IDLE; lfsr = 1; signature = 0; pattern_count = 0.
  - busy = done = pass = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - func_out = core(func_in), combinational, with no fault_mask applied.
  - start = 1 (with abort = 0) at edge t: lfsr <= seed (0 is replaced by 1), signature <= 0, pattern_count <= 0, go to RUN.
- RUN:
  - func_out is driven to 0. busy = 1.
  - Lane k core input bit j = lfsr[(5k+j) mod LFSR_W].
  - Each cycle: d = core outputs XOR fault_mask, XOR-folded to MISR_W (bit i = XOR of d[m] over all m with m mod MISR_W == i).
  - signature <= {signature[MISR_W-2:0], ^(signature & MISR_TAPS)} ^ d_fold.
  - lfsr advances one step; pattern_count increments.
  - The cycle that brings pattern_count to PATTERNS moves to DONE.
  - start is ignored in RUN.
- DONE:
  - done = 1; pass = (signature == golden), evaluated continuously so a golden change updates pass.
  - signature and pattern_count are held.
  - func_out returns to core(func_in).
  - start re-arms a run exactly as from IDLE.
- abort in any state: next edge goes to IDLE. Signature and pattern_count are held for debug; done and pass clear.
- Latency:
  - start sampled at edge t gives busy = 1 after t; the first pattern is compacted at edge t+1.
  - done = 1 after edge t+PATTERNS.
- Arithmetic:
  - No LFSR lock-up: the seed-0 substitution guarantees a nonzero start state.
  - pattern_count saturates at PATTERNS and never wraps.
- Registered state: state, lfsr, signature, pattern_count. pass is combinational from registers and golden.

Test Plan:
- Functional mode, LANES = 4, all in IDLE:
  - lane 0 {in7,in6,in3,in2,in1} = 00000 -> o23 = 0, o22 = 0.
  - lane 1 = 11111 -> o23 = 0, o22 = 1.
  - lane 2 = 00010 (in2 = 1) -> o23 = 1, o22 = 1.
  - lane 3 = 00101 (in1 = in3 = 1) -> o23 = 0, o22 = 1.
- BIST golden run: seed = 16'hACE1, PATTERNS = 255, fault_mask = 0.
  - done rises exactly 255 cycles after start; pattern_count = 255.
  - signature matches the bench reference model; with golden set to that value, pass = 1.
- Fault detection: repeat with fault_mask = 8'h01 (lane 0 o22 flipped) -> signature differs from the golden run, pass = 0.
- Seed zero: seed = 0 -> behaviour is identical to seed = 1, including the same final signature.
- Abort and reset:
  - abort at pattern 100 -> IDLE next cycle, busy = 0, done = 0, pattern_count = 100 held.
  - rst_n pulled low mid-RUN (asynchronous, between edges) -> all outputs at reset values immediately.
- Back-to-back runs: start asserted in DONE -> new run begins, signature cleared, second signature equals the first for the same seed.
